// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory.
// The load/store mode encodings match the pipeline's control decode.
package mem_pkg;

  typedef enum logic [2:0] {
    LD_WORD   = 3'b000,
    LD_HALF_S = 3'b001,
    LD_HALF_U = 3'b010,
    LD_BYTE_S = 3'b011,
    LD_BYTE_U = 3'b100
  } ld_mode_e;

  typedef enum logic [1:0] {
    ST_WORD = 2'b00,
    ST_HALF = 2'b01,
    ST_BYTE = 2'b10
  } st_mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  // Access size in bytes for a load or store mode; 0 marks an illegal encoding.
  function automatic logic [2:0] size_of(input logic is_store, input logic [2:0] mode);
    size_of = 3'd0;
    if (is_store) begin
      if (!mode[2]) begin
        case (mode[1:0])
          ST_WORD: size_of = 3'd4;
          ST_HALF: size_of = 3'd2;
          ST_BYTE: size_of = 3'd1;
          default: size_of = 3'd0;
        endcase
      end
    end else begin
      case (mode)
        LD_WORD:              size_of = 3'd4;
        LD_HALF_S, LD_HALF_U: size_of = 3'd2;
        LD_BYTE_S, LD_BYTE_U: size_of = 3'd1;
        default:              size_of = 3'd0;
      endcase
    end
  endfunction

endpackage

// File: rtl/mem_data_ram_ctrl_if.sv
// Request/response bus between the MEM stage and the data memory.
// The pipeline side is the master, the memory controller the slave.
interface mem_data_ram_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            load_mode;
  logic [1:0]            store_mode;
  logic [ADDR_WIDTH-1:0] address;
  logic [31:0]           write_data;
  logic                  resp_valid;
  logic                  resp_err;
  logic [31:0]           read_data;

  modport master (
    output req_valid, mem_read, mem_write, load_mode, store_mode, address, write_data,
    input  req_ready, resp_valid, resp_err, read_data
  );

  modport slave (
    input  req_valid, mem_read, mem_write, load_mode, store_mode, address, write_data,
    output req_ready, resp_valid, resp_err, read_data
  );
endinterface

// File: rtl/load_extend_unit.sv
// Selects the addressed half/byte from a fetched big-endian word and
// sign- or zero-extends it to 32 bits.
module load_extend_unit
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  byte_off_i,
  input  logic [2:0]  load_mode_i,
  output logic [31:0] data_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    data_o   = '0;
    half_sel = byte_off_i[1] ? word_i[15:0] : word_i[31:16];
    case (byte_off_i)
      2'd0:    byte_sel = word_i[31:24];
      2'd1:    byte_sel = word_i[23:16];
      2'd2:    byte_sel = word_i[15:8];
      default: byte_sel = word_i[7:0];
    endcase

    case (load_mode_i)
      LD_WORD:   data_o = word_i;
      LD_HALF_S: data_o = {{16{half_sel[15]}}, half_sel};
      LD_HALF_U: data_o = {16'h0000, half_sel};
      LD_BYTE_S: data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BYTE_U: data_o = {24'h000000, byte_sel};
      default:   data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_data_ram_ctrl.sv
// Clocked big-endian data memory with valid/ready request handshake,
// programmable wait states and an error response for illegal accesses.
module mem_data_ram_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input logic                clk,
  input logic                reset,
  mem_data_ram_ctrl_if.slave bus
);

  localparam int IW = $clog2(DEPTH_BYTES);
  typedef logic [IW-1:0]       idx_t;
  typedef logic [ADDR_WIDTH:0] ext_addr_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic [31:0] read_data_q, read_data_d;
  logic        resp_err_q, resp_err_d;

  logic                  rd_q, wr_q;
  logic [2:0]            ld_mode_q;
  logic [1:0]            st_mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [7:0]            ram_q [DEPTH_BYTES];

  logic                  accept, commit, live;
  logic                  cur_rd, cur_wr;
  logic [2:0]            cur_ld;
  logic [1:0]            cur_st;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           cur_wdata;
  logic [2:0]            size;
  ext_addr_t             end_addr;
  logic                  err;
  idx_t                  idx, base;
  logic [31:0]           fetch, ext_data;

  assign accept = (state_q == S_IDLE) && req_ready_q && bus.req_valid
                  && (bus.mem_read || bus.mem_write);

  // With no wait states the access completes on the accepting edge, so the
  // live bus fields are used while idle and the latched copy otherwise.
  assign live      = (state_q == S_IDLE);
  assign cur_rd    = live ? bus.mem_read   : rd_q;
  assign cur_wr    = live ? bus.mem_write  : wr_q;
  assign cur_ld    = live ? bus.load_mode  : ld_mode_q;
  assign cur_st    = live ? bus.store_mode : st_mode_q;
  assign cur_addr  = live ? bus.address    : addr_q;
  assign cur_wdata = live ? bus.write_data : wdata_q;

  assign size     = size_of(cur_wr, cur_wr ? {1'b0, cur_st} : cur_ld);
  assign end_addr = {1'b0, cur_addr} + ext_addr_t'(size) - ext_addr_t'(1);
  assign err      = (cur_rd && cur_wr)
                  || (size == 3'd0)
                  || ((size == 3'd4) && (cur_addr[1:0] != 2'b00))
                  || ((size == 3'd2) && cur_addr[0])
                  || (end_addr >= ext_addr_t'(DEPTH_BYTES));

  assign idx   = cur_addr[IW-1:0];
  assign base  = {idx[IW-1:2], 2'b00};
  assign fetch = {ram_q[base], ram_q[base | idx_t'(1)],
                  ram_q[base | idx_t'(2)], ram_q[base | idx_t'(3)]};

  load_extend_unit u_load_extend (
    .word_i      (fetch),
    .byte_off_i  (idx[1:0]),
    .load_mode_i (cur_ld),
    .data_o      (ext_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (WAIT_STATES > 0) ? S_BUSY : S_DONE;
          cnt_d   = 4'(WAIT_STATES - 1);
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    commit      = (state_d == S_DONE) && (state_q != S_DONE);

    read_data_d = read_data_q;
    resp_err_d  = resp_err_q;
    if (commit) begin
      resp_err_d  = err;
      read_data_d = (err || cur_wr) ? 32'h0 : ext_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      read_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      read_data_q <= read_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // NOTE: the RAM array and request latches are deliberately not reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      rd_q      <= bus.mem_read;
      wr_q      <= bus.mem_write;
      ld_mode_q <= bus.load_mode;
      st_mode_q <= bus.store_mode;
      addr_q    <= bus.address;
      wdata_q   <= bus.write_data;
    end
    if (commit && !reset && cur_wr && !err) begin
      case (cur_st)
        ST_WORD: begin
          ram_q[base]              <= cur_wdata[31:24];
          ram_q[base | idx_t'(1)]  <= cur_wdata[23:16];
          ram_q[base | idx_t'(2)]  <= cur_wdata[15:8];
          ram_q[base | idx_t'(3)]  <= cur_wdata[7:0];
        end
        ST_HALF: begin
          ram_q[idx]              <= cur_wdata[15:8];
          ram_q[idx | idx_t'(1)]  <= cur_wdata[7:0];
        end
        ST_BYTE: ram_q[idx] <= cur_wdata[7:0];
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = (state_q == S_DONE);
  assign bus.resp_err   = resp_err_q;
  assign bus.read_data  = read_data_q;

endmodule

// File: tb/tb_mem_data_ram_ctrl.sv
// Scoreboard bench: two controller instances (0 and 3 wait states) share
// stimulus; expected responses are queued at issue and checked on resp_valid.
module tb_mem_data_ram_ctrl;
  import mem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          sel = 0;
  logic        req_valid = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  load_mode = 3'd0;
  logic [1:0]  store_mode = 2'd0;
  logic [31:0] address = 32'h0, write_data = 32'h0;

  mem_data_ram_ctrl_if #(.ADDR_WIDTH(AW)) if0 ();
  mem_data_ram_ctrl_if #(.ADDR_WIDTH(AW)) if3 ();

  assign if0.req_valid  = req_valid && (sel == 0);
  assign if3.req_valid  = req_valid && (sel == 3);
  assign if0.mem_read   = mem_read;    assign if3.mem_read   = mem_read;
  assign if0.mem_write  = mem_write;   assign if3.mem_write  = mem_write;
  assign if0.load_mode  = load_mode;   assign if3.load_mode  = load_mode;
  assign if0.store_mode = store_mode;  assign if3.store_mode = store_mode;
  assign if0.address    = address;     assign if3.address    = address;
  assign if0.write_data = write_data;  assign if3.write_data = write_data;

  mem_data_ram_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  mem_data_ram_ctrl #(.DEPTH_BYTES(DEPTH), .ADDR_WIDTH(AW), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .bus(if3));

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   resp_count = 0, last_resp_cyc = 0;

  function automatic logic rdy(input int s);
    return (s == 3) ? if3.req_ready : if0.req_ready;
  endfunction

  function automatic int ws(input int s);
    return (s == 3) ? 3 : 0;
  endfunction

  // Response monitor: every resp_valid pulse is popped against the scoreboard.
  exp_t        mon_e;
  int          mon_who;
  logic [31:0] mon_d;
  logic        mon_err;
  always @(negedge clk) begin
    if (if0.resp_valid === 1'b1 || if3.resp_valid === 1'b1) begin
      mon_who = (if3.resp_valid === 1'b1) ? 3 : 0;
      mon_d   = (mon_who == 3) ? if3.read_data : if0.read_data;
      mon_err = (mon_who == 3) ? if3.resp_err  : if0.resp_err;
      resp_count++;
      last_resp_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp dut=%0d data=%h err=%b (no response was pending)",
                 mon_who, mon_d, mon_err);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.sel != mon_who || mon_d !== mon_e.data || mon_err !== mon_e.err) begin
          errors++;
          $display("FAIL resp_data dut=%0d got data=%h err=%b, want dut=%0d data=%h err=%b",
                   mon_who, mon_d, mon_err, mon_e.sel, mon_e.data, mon_e.err);
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [2:0] lm,
                       input logic [1:0] sm, input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; load_mode = lm; store_mode = sm;
    address = a; write_data = wd;
  endtask

  task automatic issue(input int s, input logic rd, input logic wr, input logic [2:0] lm,
                       input logic [1:0] sm, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    int   base_cnt, acc;
    bit   ok;
    e.sel = s; e.data = exp_d; e.err = exp_e;
    @(negedge clk);
    sel = s;
    drive(rd, wr, lm, sm, a, wd);
    req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (rdy(s) === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout dut=%0d addr=%h: req_ready never 1, want 1", s, a);
      req_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    base_cnt = resp_count;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    acc = cyc;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (resp_count > base_cnt) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL resp_timeout dut=%0d addr=%h: no resp_valid, want one", s, a);
      if (sb.size() > 0) void'(sb.pop_back());
    end else if (last_resp_cyc - acc + 1 != ws(s) + 1) begin
      errors++;
      $display("FAIL latency dut=%0d got %0d cycles, want %0d",
               s, last_resp_cyc - acc + 1, ws(s) + 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s <= 3; s += 3) begin
      checks++;
      if (rdy(s) !== 1'b0) begin
        errors++; $display("FAIL reset_ready dut=%0d got %b want 0", s, rdy(s));
      end
      checks++;
      if (((s == 3) ? if3.resp_valid : if0.resp_valid) !== 1'b0) begin
        errors++; $display("FAIL reset_resp_valid dut=%0d want 0", s);
      end
      checks++;
      if (((s == 3) ? if3.read_data : if0.read_data) !== 32'h0) begin
        errors++; $display("FAIL reset_read_data dut=%0d want 0", s);
      end
      checks++;
      if (((s == 3) ? if3.resp_err : if0.resp_err) !== 1'b0) begin
        errors++; $display("FAIL reset_resp_err dut=%0d want 0", s);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s <= 3; s += 3) begin
      checks++;
      if (rdy(s) !== 1'b1) begin
        errors++; $display("FAIL ready_after_reset dut=%0d got %b want 1", s, rdy(s));
      end
    end
  endtask

  task automatic test_word();
    issue(0, 1'b0, 1'b1, LD_WORD, ST_WORD, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(0, 1'b1, 1'b0, LD_WORD, ST_WORD, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_load_ext();
    issue(0, 1'b1, 1'b0, LD_HALF_S, ST_WORD, 32'h10, 32'h0, 32'hFFFFDEAD, 1'b0);
    issue(0, 1'b1, 1'b0, LD_HALF_U, ST_WORD, 32'h12, 32'h0, 32'h0000BEEF, 1'b0);
    issue(0, 1'b1, 1'b0, LD_BYTE_S, ST_WORD, 32'h13, 32'h0, 32'hFFFFFFEF, 1'b0);
    issue(0, 1'b1, 1'b0, LD_BYTE_U, ST_WORD, 32'h11, 32'h0, 32'h000000AD, 1'b0);
    issue(0, 1'b1, 1'b0, LD_BYTE_S, ST_WORD, 32'h12, 32'h0, 32'hFFFFFFBE, 1'b0);
  endtask

  task automatic test_partial_store();
    issue(0, 1'b0, 1'b1, LD_WORD, ST_BYTE, 32'h11, 32'hAABBCC55, 32'h0, 1'b0);
    issue(0, 1'b1, 1'b0, LD_WORD, ST_WORD, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0);
    issue(0, 1'b0, 1'b1, LD_WORD, ST_HALF, 32'h12, 32'h99991234, 32'h0, 1'b0);
    issue(0, 1'b1, 1'b0, LD_WORD, ST_WORD, 32'h10, 32'h0, 32'hDE551234, 1'b0);
  endtask

  task automatic test_errors();
    issue(0, 1'b1, 1'b0, LD_WORD, ST_WORD, 32'h12, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 1'b1, LD_WORD, ST_WORD, DEPTH - 2, 32'h01020304, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b0, LD_WORD, ST_WORD, 32'h10, 32'h0, 32'hDE551234, 1'b0);
    issue(0, 1'b1, 1'b1, LD_WORD, ST_WORD, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b101, ST_WORD, 32'h10, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b0, 1'b1, LD_WORD, 2'b11, 32'h10, 32'h77777777, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b0, LD_WORD, ST_WORD, 32'h10, 32'h0, 32'hDE551234, 1'b0);
    issue(0, 1'b0, 1'b1, LD_WORD, ST_BYTE, DEPTH - 1, 32'h0000007E, 32'h0, 1'b0);
    issue(0, 1'b1, 1'b0, LD_BYTE_U, ST_WORD, DEPTH - 1, 32'h0, 32'h0000007E, 1'b0);
    issue(0, 1'b1, 1'b0, LD_HALF_U, ST_WORD, DEPTH - 1, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b0, LD_WORD, ST_WORD, DEPTH, 32'h0, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b0, LD_WORD, ST_WORD, 32'h80000010, 32'h0, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (if0.resp_err !== 1'b1 || if0.read_data !== 32'h0) begin
      errors++;
      $display("FAIL hold_after_err got err=%b data=%h want err=1 data=0",
               if0.resp_err, if0.read_data);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   base_cnt, acc, acc2;
    bit   ok;
    issue(3, 1'b0, 1'b1, LD_WORD, ST_WORD, 32'h10, 32'hA5A50F0F, 32'h0, 1'b0);
    issue(3, 1'b1, 1'b0, LD_WORD, ST_WORD, 32'h10, 32'h0, 32'hA5A50F0F, 1'b0);
    @(negedge clk);
    sel = 3;
    drive(1'b1, 1'b0, LD_WORD, ST_WORD, 32'h10, 32'h0);
    req_valid = 1'b1;
    checks++;
    if (rdy(3) !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_idle got %b want 1", rdy(3));
    end
    e.sel = 3; e.data = 32'hA5A50F0F; e.err = 1'b0;
    sb.push_back(e);
    base_cnt = resp_count;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    drive(1'b1, 1'b0, LD_HALF_U, ST_WORD, 32'h12, 32'h0);
    e.data = 32'h00000F0F;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rdy(3) !== 1'b0) begin
        errors++; $display("FAIL b2b_ready_busy cycle=%0d got %b want 0", i + 1, rdy(3));
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (resp_count != base_cnt + 1 || last_resp_cyc - acc + 1 != 4) begin
      errors++;
      $display("FAIL b2b_first_resp got count=%0d latency=%0d want count=%0d latency=4",
               resp_count - base_cnt, last_resp_cyc - acc + 1, 1);
    end
    checks++;
    if (rdy(3) !== 1'b1) begin
      errors++; $display("FAIL b2b_ready_back got %b want 1", rdy(3));
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    acc2 = cyc;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (resp_count >= base_cnt + 2) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || last_resp_cyc - acc2 + 1 != 4) begin
      errors++;
      $display("FAIL b2b_second_resp got seen=%0d latency=%0d want seen=1 latency=4",
               ok, last_resp_cyc - acc2 + 1);
      if (!ok && sb.size() > 0) void'(sb.pop_back());
    end
  endtask

  task automatic test_reset_midop();
    int base_cnt;
    issue(3, 1'b0, 1'b1, LD_WORD, ST_WORD, 32'h20, 32'h11223344, 32'h0, 1'b0);
    @(negedge clk);
    sel = 3;
    drive(1'b0, 1'b1, LD_WORD, ST_WORD, 32'h20, 32'hCAFEF00D);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    base_cnt = resp_count;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (rdy(3) !== 1'b0) begin
        errors++; $display("FAIL midop_ready_in_reset got %b want 0", rdy(3));
      end
    end
    reset = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (rdy(3) !== 1'b1) begin
      errors++; $display("FAIL midop_ready_after got %b want 1", rdy(3));
    end
    checks++;
    if (resp_count != base_cnt) begin
      errors++;
      $display("FAIL midop_no_resp got %0d responses want 0", resp_count - base_cnt);
    end
    issue(3, 1'b1, 1'b0, LD_WORD, ST_WORD, 32'h20, 32'h0, 32'h11223344, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word();
    test_load_ext();
    test_partial_store();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
